// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage, hazard unit and decode.
// Holds the datapath width, the bubble instruction, the default reset PC,
// register-field bit positions and the PC next-value select encoding.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_PC = '0;

    localparam int REG_ADDR_W = 5;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_LOAD = 2'd1,
        PC_INC  = 2'd2
    } pc_sel_e;

    function automatic logic [REG_ADDR_W-1:0] rs1_of(input logic [31:0] instr);
        return instr[RS1_LSB +: REG_ADDR_W];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] rs2_of(input logic [31:0] instr);
        return instr[RS2_LSB +: REG_ADDR_W];
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of every signal the fetch stage exchanges with its neighbours:
// stall/redirect control in, instruction-memory bus, IF/ID payload out.
//   master : the fetch stage itself (drives imem_addr and the IF/ID payload)
//   slave  : the environment (hazard unit, EX redirect, imem, decode)
// Optional feature macro: IF_PERF_COUNTERS_EN adds Stall_Count/Flush_Count.
interface if_stage_if;
    import rv32i_pkg::*;

    logic                  Stall;
    logic                  Redirect;
    logic [XLEN-1:0]       Redirect_Target;
    logic [XLEN-1:0]       imem_addr;
    logic [31:0]           imem_rdata;
    logic [XLEN-1:0]       IF_ID_PC;
    logic [XLEN-1:0]       IF_ID_PC4;
    logic [31:0]           IF_ID_Instr;
    logic                  IF_ID_Valid;
    logic [REG_ADDR_W-1:0] IF_ID_Rs1;
    logic [REG_ADDR_W-1:0] IF_ID_Rs2;

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0]           Stall_Count;
    logic [31:0]           Flush_Count;

    modport master (
        input  Stall, Redirect, Redirect_Target, imem_rdata,
        output imem_addr, IF_ID_PC, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid,
               IF_ID_Rs1, IF_ID_Rs2, Stall_Count, Flush_Count
    );

    modport slave (
        output Stall, Redirect, Redirect_Target, imem_rdata,
        input  imem_addr, IF_ID_PC, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid,
               IF_ID_Rs1, IF_ID_Rs2, Stall_Count, Flush_Count
    );
`else
    modport master (
        input  Stall, Redirect, Redirect_Target, imem_rdata,
        output imem_addr, IF_ID_PC, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid,
               IF_ID_Rs1, IF_ID_Rs2
    );

    modport slave (
        output Stall, Redirect, Redirect_Target, imem_rdata,
        input  imem_addr, IF_ID_PC, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid,
               IF_ID_Rs1, IF_ID_Rs2
    );
`endif

endinterface

// File: rtl/pc_reg.sv
// Program counter register with hold / load / increment select.
// Ports:
//   clk, rst  : clock, async active-high reset (PC <= RESET_PC)
//   pc_sel    : PC_HOLD keeps the value, PC_LOAD takes load_pc, PC_INC adds 4
//   load_pc   : value loaded on PC_LOAD (caller aligns it)
//   pc        : current PC
module pc_reg
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         pc_sel,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            PC_HOLD: pc_d = pc_q;
            PC_LOAD: pc_d = load_pc;
            PC_INC:  pc_d = pc_q + XLEN'(4);   // wraps modulo 2^XLEN
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the instruction-memory
// address and holds the IF/ID pipeline register.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : if_stage_if.master -- Stall/Redirect/Redirect_Target and
//              imem_rdata in; imem_addr and IF_ID_{PC,PC4,Instr,Valid,Rs1,Rs2}
//              out (plus Stall_Count/Flush_Count with IF_PERF_COUNTERS_EN)
// Priority on each edge: Redirect > Stall > normal fetch.
// Optional feature macro: IF_PERF_COUNTERS_EN (saturating stall/flush counters).
module if_stage
    import rv32i_pkg::*;
#(
    parameter int              XLEN      = rv32i_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = rv32i_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);

    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_pc;

    logic [XLEN-1:0] if_id_pc_d,    if_id_pc_q;
    logic [31:0]     if_id_instr_d, if_id_instr_q;
    logic            if_id_valid_d, if_id_valid_q;

    // Targets are forced word-aligned; misaligned low bits are simply dropped.
    assign redirect_pc = bus.Redirect_Target & ~XLEN'(3);

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .pc_sel  (pc_sel),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    always_comb begin
        pc_sel        = PC_INC;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (bus.Redirect) begin
            pc_sel        = PC_LOAD;
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (bus.Stall) begin
            // imem_rdata is dropped; the same PC is fetched again next cycle.
            pc_sel = PC_HOLD;
        end else begin
            pc_sel        = PC_INC;
            if_id_pc_d    = pc;
            if_id_instr_d = bus.imem_rdata;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.IF_ID_PC    = if_id_pc_q;
    assign bus.IF_ID_PC4   = if_id_pc_q + XLEN'(4);
    assign bus.IF_ID_Instr = if_id_instr_q;
    assign bus.IF_ID_Valid = if_id_valid_q;
    assign bus.IF_ID_Rs1   = rs1_of(if_id_instr_q);
    assign bus.IF_ID_Rs2   = rs2_of(if_id_instr_q);

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] stall_count_d, stall_count_q;
    logic [31:0] flush_count_d, flush_count_q;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (bus.Redirect) begin
            if (flush_count_q != '1) begin
                flush_count_d = flush_count_q + 32'd1;
            end
        end else if (bus.Stall) begin
            if (stall_count_q != '1) begin
                stall_count_d = stall_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.Stall_Count = stall_count_q;
    assign bus.Flush_Count = flush_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] pc;
        logic [31:0] if_pc;
        logic [31:0] instr;
        logic        valid;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    vec_t sb[$];
    vec_t tbl[18];

    logic [31:0] m_pc, m_if_pc, m_instr;
    logic        m_valid;
    int          m_stalls, m_flushes;

    if_stage_if bus();

    if_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                                input logic [31:0] pc, input logic [31:0] ipc,
                                input logic [31:0] ins, input logic v);
        vec_t x;
        x.stall = s; x.redirect = r; x.target = t;
        x.pc = pc; x.if_pc = ipc; x.instr = ins; x.valid = v;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_if_pc = 32'h0; m_instr = 32'h0000_0013; m_valid = 1'b0;
        m_stalls = 0; m_flushes = 0;
    endtask

    task automatic check_reset_values();
        chk("rst imem_addr", bus.imem_addr, 32'h0);
        chk("rst IF_ID_PC", bus.IF_ID_PC, 32'h0);
        chk("rst IF_ID_PC4", bus.IF_ID_PC4, 32'h4);
        chk("rst IF_ID_Instr", bus.IF_ID_Instr, 32'h0000_0013);
        chk("rst IF_ID_Valid", 32'(bus.IF_ID_Valid), 32'h0);
        chk("rst IF_ID_Rs1", 32'(bus.IF_ID_Rs1), 32'h0);
        chk("rst IF_ID_Rs2", 32'(bus.IF_ID_Rs2), 32'h0);
`ifdef IF_PERF_COUNTERS_EN
        chk("rst Stall_Count", bus.Stall_Count, 32'h0);
        chk("rst Flush_Count", bus.Flush_Count, 32'h0);
`endif
    endtask

    // Drives one cycle, advances the reference model, pushes the expectation
    // (table row if given, model otherwise), then pops and compares after the edge.
    task automatic step(input logic s, input logic r, input logic [31:0] t,
                        input logic use_row, input vec_t row);
        vec_t e;
        vec_t g;
        bus.Stall = s;
        bus.Redirect = r;
        bus.Redirect_Target = t;
        if (r) begin
            m_pc = t & 32'hFFFF_FFFC;
            m_if_pc = 32'h0; m_instr = 32'h0000_0013; m_valid = 1'b0;
            m_flushes++;
        end else if (s) begin
            m_stalls++;
        end else begin
            m_if_pc = m_pc; m_instr = mem_word(m_pc); m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        e = mk(s, r, t, m_pc, m_if_pc, m_instr, m_valid);
        sb.push_back(use_row ? row : e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            g = sb.pop_front();
            chk("imem_addr", bus.imem_addr, g.pc);
            chk("IF_ID_PC", bus.IF_ID_PC, g.if_pc);
            chk("IF_ID_PC4", bus.IF_ID_PC4, g.if_pc + 32'd4);
            chk("IF_ID_Instr", bus.IF_ID_Instr, g.instr);
            chk("IF_ID_Valid", 32'(bus.IF_ID_Valid), 32'(g.valid));
            chk("IF_ID_Rs1", 32'(bus.IF_ID_Rs1), 32'(g.instr[19:15]));
            chk("IF_ID_Rs2", 32'(bus.IF_ID_Rs2), 32'(g.instr[24:20]));
        end
    endtask

    initial begin
        vec_t dummy;
        n_cmp = 0; n_err = 0;
        dummy = mk(0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk(0, 0, 32'h0,        32'h4,        32'h0,        mem_word(32'h0),   1);
        tbl[1]  = mk(0, 0, 32'h0,        32'h8,        32'h4,        mem_word(32'h4),   1);
        tbl[2]  = mk(0, 0, 32'h0,        32'hC,        32'h8,        mem_word(32'h8),   1);
        tbl[3]  = mk(0, 0, 32'h0,        32'h10,       32'hC,        mem_word(32'hC),   1);
        tbl[4]  = mk(1, 0, 32'h0,        32'h10,       32'hC,        mem_word(32'hC),   1);
        tbl[5]  = mk(1, 0, 32'h0,        32'h10,       32'hC,        mem_word(32'hC),   1);
        tbl[6]  = mk(0, 0, 32'h0,        32'h14,       32'h10,       mem_word(32'h10),  1);
        tbl[7]  = mk(0, 0, 32'h0,        32'h18,       32'h14,       mem_word(32'h14),  1);
        tbl[8]  = mk(0, 0, 32'h0,        32'h1C,       32'h18,       mem_word(32'h18),  1);
        tbl[9]  = mk(0, 0, 32'h0,        32'h20,       32'h1C,       mem_word(32'h1C),  1);
        tbl[10] = mk(0, 1, 32'h100,      32'h100,      32'h0,        32'h0000_0013,     0);
        tbl[11] = mk(0, 0, 32'h0,        32'h104,      32'h100,      mem_word(32'h100), 1);
        tbl[12] = mk(1, 1, 32'h203,      32'h200,      32'h0,        32'h0000_0013,     0);
        tbl[13] = mk(1, 0, 32'h0,        32'h200,      32'h0,        32'h0000_0013,     0);
        tbl[14] = mk(0, 0, 32'h0,        32'h204,      32'h200,      mem_word(32'h200), 1);
        tbl[15] = mk(0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0,      32'h0000_0013,     0);
        tbl[16] = mk(0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1);
        tbl[17] = mk(0, 0, 32'h0,        32'h4,        32'h0,        mem_word(32'h0),   1);

        rst = 1'b1;
        bus.Stall = 1'b0;
        bus.Redirect = 1'b0;
        bus.Redirect_Target = 32'h0;
        model_reset();
        #8;
        check_reset_values();
        #4;
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].stall, tbl[i].redirect, tbl[i].target, 1'b1, tbl[i]);
        end
        chk("tbl IF_ID_Instr first", mem_word(32'h0), 32'h00A0_0093);
`ifdef IF_PERF_COUNTERS_EN
        chk("Stall_Count table", bus.Stall_Count, 32'd3);
        chk("Flush_Count table", bus.Flush_Count, 32'd3);
`endif

        for (int i = 0; i < 200; i++) begin
            logic s, r;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            t = $urandom;
            step(s, r, t, 1'b0, dummy);
        end
`ifdef IF_PERF_COUNTERS_EN
        chk("Stall_Count random", bus.Stall_Count, 32'(m_stalls));
        chk("Flush_Count random", bus.Flush_Count, 32'(m_flushes));
`endif

        // Reset asserted between edges while stalled must take effect at once.
        step(1'b1, 1'b0, 32'h0, 1'b0, dummy);
        step(1'b1, 1'b0, 32'h0, 1'b0, dummy);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        bus.Stall = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        step(1'b0, 1'b0, 32'h0, 1'b0, dummy);
        step(1'b0, 1'b0, 32'h0, 1'b0, dummy);
        chk("post-reset PC", bus.imem_addr, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the RV32I 5-stage pipeline. Holds the PC, drives instruction-memory address, and owns the IF/ID pipeline register.
- Consumes Stall from the hazard detection unit and Redirect from EX (taken branch/jump).
- Presents IF_ID_Rs1/IF_ID_Rs2 to the hazard detection unit and the IF/ID payload to decode.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Stall  input  1  load-use stall; hold PC and IF/ID.
- Redirect  input  1  taken branch/jump resolved in EX; flush.
- Redirect_Target  input  XLEN  new PC when Redirect=1.
- imem_addr  output  XLEN  instruction memory address; equals PC.
- imem_rdata  input  32  instruction word; combinational read of imem_addr.
- IF_ID_PC  output  XLEN  PC of instruction in IF/ID.
- IF_ID_PC4  output  XLEN  IF_ID_PC+4.
- IF_ID_Instr  output  32  instruction in IF/ID.
- IF_ID_Valid  output  1  1 = real instruction, 0 = bubble.
- IF_ID_Rs1  output  5  IF_ID_Instr[19:15], combinational slice.
- IF_ID_Rs2  output  5  IF_ID_Instr[24:20], combinational slice.

Behaviour:
- Reset (async, immediate): PC=RESET_PC; IF_ID_Instr=NOP_INSTR; IF_ID_PC=0; IF_ID_Valid=0. Hence IF_ID_Rs1=IF_ID_Rs2=0 and IF_ID_PC4=4. Reset mid-operation discards all in-flight state.
- imem_addr=PC combinationally. Fetch latency is 1 cycle: word at PC appears in IF/ID on the next edge.
- Per-edge priority: Redirect > Stall > normal.
- Redirect=1:
  - PC <= {Redirect_Target[XLEN-1:2],2'b00}; low bits are ignored, with no misalignment trap.
  - IF/ID <= bubble (NOP_INSTR, Valid=0, IF_ID_PC=0).
  - Stall in the same cycle is ignored.
- Stall=1, Redirect=0: PC and all IF/ID fields hold. imem_rdata is discarded and re-fetched next cycle.
- Normal: PC <= PC+4 (mod 2^XLEN, wraps 0xFFFF_FFFC -> 0); IF/ID <= {imem_rdata, PC, Valid=1}.
- Stall asserted N consecutive cycles: IF/ID is frozen for exactly N cycles, and the same PC is presented for N+1 cycles.
- No FSM beyond the PC/IF-IF/ID registers. All state updates only on rising clk or rst.

Optional Feature:
- Macro IF_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs Stall_Count[31:0] and Flush_Count[31:0].
  - Stall_Count increments on each edge with Stall=1 and Redirect=0.
  - Flush_Count increments on each edge with Redirect=1.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: ports and registers are absent; functional behaviour is identical.

Decomposition:
- Shared package rv32i_pkg holds XLEN, NOP_INSTR, the RESET_PC default, and the instruction field bit positions (RS1_LSB=15, RS2_LSB=20). The hazard unit and decode use the same package.
- One natural sub-module, pc_reg: PC register with hold/load/increment select.
- IF/ID register stays inline.

Test Plan:
- Reset release with imem returning 0x00A00093 at address 0: after 1 edge IF_ID_Instr=0x00A00093, IF_ID_PC=0, Valid=1; after 2 edges IF_ID_PC=4, PC=8.
- Stall=1 for 2 cycles at PC=0x10 with IF_ID_PC=0x0C: IF/ID holds 0x0C for 2 edges; imem_addr=0x10 for 3 cycles; then IF_ID_PC=0x10.
- Redirect=1 with Redirect_Target=0x100 at PC=0x20: next edge PC=0x100, IF_ID_Instr=0x00000013, Valid=0, Rs1=Rs2=0; following edge IF_ID_PC=0x100.
- Redirect and Stall both 1, Redirect_Target=0x203: PC=0x200, IF/ID bubble. Stall is ignored and the low bits are cleared.
- PC=0xFFFF_FFFC, no stall: next PC=0; IF_ID_PC=0xFFFF_FFFC, IF_ID_PC4=0.
- Assert rst mid-stream during a Stall: outputs immediately return to reset values without a clock edge. With IF_PERF_COUNTERS_EN defined, 3 stalls + 1 redirect give Stall_Count=3, Flush_Count=1, and both read 0 after reset.
